// File: rtl/issue_dispatcher.sv
// Dual-issue dispatcher: two-entry ordered hold buffer feeding two issue buses, gated by per-station credits.
// Issue is combinational from the hold buffer; accepted pairs issue one cycle after the accepting edge at the earliest.
module issue_dispatcher #(
  parameter int         STATION_CNT = 4,
  parameter int         SIZE        = 16,
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         PAYLOAD_W   = 176,
  localparam int        SW          = (STATION_CNT > 1) ? $clog2(STATION_CNT) : 1,
  localparam int        CW          = $clog2(SIZE + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            delete_tagged,
  input  logic [1:0]                      in_valid,
  input  logic [1:0][SW-1:0]              in_station,
  input  logic [1:0]                      in_tag,
  input  logic [1:0][PAYLOAD_W-1:0]       in_payload,
  output logic                            in_ready,
  input  logic [STATION_CNT-1:0][1:0]     credit_return,
  output logic [1:0]                      issue_valid,
  output logic [1:0][7:0]                 issue_stat_select,
  output logic [1:0]                      issue_tag,
  output logic [1:0][PAYLOAD_W-1:0]       issue_payload,
  output logic                            credit_err
);

  logic [1:0]                h_vld;
  logic [1:0][SW-1:0]        h_st;
  logic [1:0]                h_tag;
  logic [1:0][PAYLOAD_W-1:0] h_pl;
  logic [CW-1:0]             credit [STATION_CNT];

  logic [1:0]    kill;
  logic [1:0]    iss;
  logic          h0_clear;
  logic          same_st;
  logic [CW-1:0] c0, c1;
  logic [1:0]    load_v;
  logic [CW:0]   nxt [STATION_CNT];
  logic [STATION_CNT-1:0] ovf;

  always_comb begin
    kill     = {2{delete_tagged}} & h_tag & h_vld;
    c0       = credit[h_st[0]];
    c1       = credit[h_st[1]];
    iss[0]   = ~reset & h_vld[0] & ~kill[0] & (c0 != '0);
    // A dropped H0 no longer blocks H1; a stalled one does.
    h0_clear = ~h_vld[0] | iss[0] | kill[0];
    same_st  = iss[0] & (h_st[1] == h_st[0]);
    iss[1]   = ~reset & h_vld[1] & ~kill[1] & h0_clear &
               (same_st ? ({1'b0, c1} >= (CW+1)'(2)) : (c1 != '0));
    in_ready = reset | (h0_clear & (~h_vld[1] | iss[1] | kill[1]));
    load_v   = in_valid & ~({2{delete_tagged}} & in_tag);
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      issue_valid[k]       = iss[k];
      issue_stat_select[k] = iss[k] ? BASE_ADDR + 8'(h_st[k]) : 8'h00;
      issue_tag[k]         = iss[k] & h_tag[k];
      issue_payload[k]     = iss[k] ? h_pl[k] : '0;
    end
  end

  // Net credit per station: debit this cycle's issues, add returns, clamp at SIZE.
  always_comb begin
    for (int i = 0; i < STATION_CNT; i++) begin
      nxt[i] = (CW+1)'(credit[i])
             - (CW+1)'(iss[0] && (h_st[0] == SW'(i)))
             - (CW+1)'(iss[1] && (h_st[1] == SW'(i)))
             + (CW+1)'(credit_return[i]);
      ovf[i] = nxt[i] > (CW+1)'(SIZE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_vld      <= 2'b00;
      h_st       <= '0;
      h_tag      <= 2'b00;
      h_pl       <= '0;
      credit_err <= 1'b0;
      for (int i = 0; i < STATION_CNT; i++) credit[i] <= CW'(SIZE);
    end else begin
      for (int i = 0; i < STATION_CNT; i++)
        credit[i] <= ovf[i] ? CW'(SIZE) : nxt[i][CW-1:0];
      if (|ovf) credit_err <= 1'b1;

      if (in_ready) begin
        if (load_v[0]) begin
          h_vld <= {load_v[1], 1'b1};
          h_st  <= in_station;
          h_tag <= in_tag;
          h_pl  <= in_payload;
        end else begin
          h_vld    <= {1'b0, load_v[1]};
          h_st[0]  <= in_station[1];
          h_tag[0] <= in_tag[1];
          h_pl[0]  <= in_payload[1];
        end
      end else if (h0_clear) begin
        // H0 left but H1 stays: H1 becomes the head.
        h_vld    <= 2'b01;
        h_st[0]  <= h_st[1];
        h_tag[0] <= h_tag[1];
        h_pl[0]  <= h_pl[1];
      end else begin
        h_vld[1] <= h_vld[1] & ~kill[1];
      end
    end
  end

endmodule

// File: tb/tb_issue_dispatcher.sv
// Directed bench for issue_dispatcher: reset, pair issue, credit exhaustion/return, ordering, flush, overflow.
module tb_issue_dispatcher;

  localparam int PW = 176;

  logic             clk = 1'b0;
  logic             reset;
  logic             delete_tagged;
  logic [1:0]       in_valid;
  logic [1:0][1:0]  in_station;
  logic [1:0]       in_tag;
  logic [1:0][PW-1:0] in_payload;
  logic             in_ready;
  logic [3:0][1:0]  credit_return;
  logic [1:0]       issue_valid;
  logic [1:0][7:0]  issue_stat_select;
  logic [1:0]       issue_tag;
  logic [1:0][PW-1:0] issue_payload;
  logic             credit_err;

  int checks = 0;
  int passes = 0;

  issue_dispatcher dut (
    .clk               (clk),
    .reset             (reset),
    .delete_tagged     (delete_tagged),
    .in_valid          (in_valid),
    .in_station        (in_station),
    .in_tag            (in_tag),
    .in_payload        (in_payload),
    .in_ready          (in_ready),
    .credit_return     (credit_return),
    .issue_valid       (issue_valid),
    .issue_stat_select (issue_stat_select),
    .issue_tag         (issue_tag),
    .issue_payload     (issue_payload),
    .credit_err        (credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pl(input int x);
    logic [15:0] v;
    v = x[15:0];
    return {11{v}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds n single instructions back-to-back to one station; each must issue on bus 0 the next cycle.
  task automatic stream(input int st, input int n, input int base);
    in_valid      = 2'b01;
    in_station[0] = 2'(st);
    in_tag        = 2'b00;
    in_payload[0] = pl(base);
    tick();
    for (int i = 1; i < n; i++) begin
      chk("stream_vld", issue_valid, 2'b01);
      chk("stream_pl", issue_payload[0], pl(base + i - 1));
      in_payload[0] = pl(base + i);
      tick();
    end
    in_valid = 2'b00;
    chk("stream_vld_last", issue_valid, 2'b01);
    chk("stream_pl_last", issue_payload[0], pl(base + n - 1));
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    delete_tagged = 1'b0;
    in_valid      = 2'b11;
    in_station    = '0;
    in_tag        = 2'b00;
    in_payload    = '0;
    credit_return = '0;
    tick();
    tick();
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", issue_valid, 2'b00);

    reset    = 1'b0;
    in_valid = 2'b00;
    tick();
    chk("idle_valid", issue_valid, 2'b00);
    chk("idle_sel", issue_stat_select, 16'h0000);
    chk("idle_tag", issue_tag, 2'b00);
    chk("idle_pl0", issue_payload[0], '0);
    chk("idle_pl1", issue_payload[1], '0);
    chk("idle_ready", in_ready, 1'b1);
    chk("idle_err", credit_err, 1'b0);

    // Pair to stations 1 and 2 issues together next cycle.
    in_valid = 2'b11;
    in_station[0] = 2'd1; in_payload[0] = pl('h11);
    in_station[1] = 2'd2; in_payload[1] = pl('h22);
    tick();
    in_valid = 2'b00;
    chk("pair_valid", issue_valid, 2'b11);
    chk("pair_sel0", issue_stat_select[0], 8'h01);
    chk("pair_sel1", issue_stat_select[1], 8'h02);
    chk("pair_pl0", issue_payload[0], pl('h11));
    chk("pair_pl1", issue_payload[1], pl('h22));
    tick();
    chk("pair_drain", issue_valid, 2'b00);

    // Exhaust station 0, 17th stalls until one credit returns.
    stream(0, 16, 'h100);
    in_valid = 2'b01; in_station[0] = 2'd0; in_payload[0] = pl('h1FF);
    tick();
    in_valid = 2'b00;
    chk("exh_stall_vld", issue_valid, 2'b00);
    chk("exh_stall_rdy", in_ready, 1'b0);
    credit_return[0] = 2'd1;
    tick();
    credit_return = '0;
    chk("exh_ret_vld", issue_valid, 2'b01);
    chk("exh_ret_pl", issue_payload[0], pl('h1FF));
    chk("exh_ret_rdy", in_ready, 1'b1);
    tick();

    // Reset while stalled on zero credit discards the held instruction.
    in_valid = 2'b01; in_station[0] = 2'd0; in_payload[0] = pl('h333);
    tick();
    in_valid = 2'b00;
    chk("mid_stall_vld", issue_valid, 2'b00);
    reset = 1'b1;
    in_valid = 2'b11;
    credit_return = {4{2'd2}};
    #1;
    chk("mid_rst_rdy", in_ready, 1'b1);
    chk("mid_rst_vld", issue_valid, 2'b00);
    tick();
    reset = 1'b0;
    in_valid = 2'b00;
    credit_return = '0;
    #1;
    chk("post_rst_vld", issue_valid, 2'b00);
    chk("post_rst_sel", issue_stat_select, 16'h0000);
    chk("post_rst_pl0", issue_payload[0], '0);
    chk("post_rst_rdy", in_ready, 1'b1);
    chk("post_rst_err", credit_err, 1'b0);
    tick();

    // Overflow: credit 15 plus return of 2 clamps and sets the sticky error.
    stream(0, 1, 'h400);
    chk("pre_ovf_err", credit_err, 1'b0);
    credit_return[0] = 2'd2;
    tick();
    credit_return = '0;
    chk("ovf_err", credit_err, 1'b1);
    tick();
    tick();
    chk("ovf_err_sticky", credit_err, 1'b1);

    // Clamped value is exactly 16; then a stalled H0 blocks H1 on another station.
    stream(0, 16, 'h500);
    in_valid = 2'b11;
    in_station[0] = 2'd0; in_payload[0] = pl('h5AA);
    in_station[1] = 2'd1; in_payload[1] = pl('h5BB);
    tick();
    in_valid = 2'b00;
    chk("hol_vld", issue_valid, 2'b00);
    chk("hol_rdy", in_ready, 1'b0);
    credit_return[0] = 2'd1;
    tick();
    credit_return = '0;
    chk("hol_rel_vld", issue_valid, 2'b11);
    chk("hol_rel_sel0", issue_stat_select[0], 8'h00);
    chk("hol_rel_sel1", issue_stat_select[1], 8'h01);
    chk("hol_rel_pl1", issue_payload[1], pl('h5BB));
    tick();
    chk("err_still", credit_err, 1'b1);

    // Station 3 left with one credit, pair to station 3.
    stream(3, 15, 'h600);
    in_valid = 2'b11;
    in_station[0] = 2'd3; in_payload[0] = pl('h6AA);
    in_station[1] = 2'd3; in_payload[1] = pl('h6BB);
    tick();
    in_valid = 2'b00;
    chk("s3_vld", issue_valid, 2'b01);
    chk("s3_sel0", issue_stat_select[0], 8'h03);
    chk("s3_pl0", issue_payload[0], pl('h6AA));
    chk("s3_rdy", in_ready, 1'b0);
    tick();
    chk("s3_shift_vld", issue_valid, 2'b00);
    chk("s3_shift_rdy", in_ready, 1'b0);
    credit_return[3] = 2'd1;
    tick();
    chk("s3_ret_vld", issue_valid, 2'b01);
    chk("s3_ret_pl", issue_payload[0], pl('h6BB));
    chk("s3_ret_rdy", in_ready, 1'b1);
    // Return lands in the same cycle as this issue: net credit stays 1.
    tick();
    credit_return = '0;
    chk("s3_net_idle", issue_valid, 2'b00);
    in_valid = 2'b01; in_station[0] = 2'd3; in_payload[0] = pl('h6CC);
    tick();
    in_valid = 2'b00;
    chk("s3_net_vld", issue_valid, 2'b01);
    chk("s3_net_pl", issue_payload[0], pl('h6CC));
    tick();

    // Flush of a tagged H1 behind an untagged stalled H0 (station 0 has no credit).
    in_valid = 2'b11;
    in_station[0] = 2'd0; in_tag[0] = 1'b0; in_payload[0] = pl('h7AA);
    in_station[1] = 2'd1; in_tag[1] = 1'b1; in_payload[1] = pl('h7BB);
    tick();
    in_valid = 2'b00;
    in_tag = 2'b00;
    chk("fl_hold_vld", issue_valid, 2'b00);
    delete_tagged = 1'b1;
    credit_return[0] = 2'd1;
    #1;
    chk("fl_pulse_vld", issue_valid, 2'b00);
    chk("fl_pulse_rdy", in_ready, 1'b0);
    tick();
    delete_tagged = 1'b0;
    credit_return = '0;
    #1;
    chk("fl_h0_vld", issue_valid, 2'b01);
    chk("fl_h0_pl", issue_payload[0], pl('h7AA));
    chk("fl_h0_tag", issue_tag, 2'b00);
    chk("fl_h0_rdy", in_ready, 1'b1);
    tick();
    chk("fl_h1_gone", issue_valid, 2'b00);

    // Tagged incoming slot 0 dropped during flush; untagged slot 1 lands in H0.
    in_valid = 2'b11;
    in_station[0] = 2'd1; in_tag[0] = 1'b1; in_payload[0] = pl('h8AA);
    in_station[1] = 2'd2; in_tag[1] = 1'b0; in_payload[1] = pl('h8BB);
    delete_tagged = 1'b1;
    tick();
    delete_tagged = 1'b0;
    in_valid = 2'b00;
    chk("fl_in_vld", issue_valid, 2'b01);
    chk("fl_in_sel0", issue_stat_select[0], 8'h02);
    chk("fl_in_pl0", issue_payload[0], pl('h8BB));
    tick();

    // Tagged pair without flush issues normally with tags forwarded.
    in_valid = 2'b11;
    in_station[0] = 2'd1; in_tag[0] = 1'b1; in_payload[0] = pl('h9AA);
    in_station[1] = 2'd2; in_tag[1] = 1'b1; in_payload[1] = pl('h9BB);
    tick();
    in_valid = 2'b00;
    in_tag = 2'b00;
    chk("tag_vld", issue_valid, 2'b11);
    chk("tag_fwd", issue_tag, 2'b11);
    tick();
    chk("final_idle", issue_valid, 2'b00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
